cpu7_tlb_sched: RTL and testbench

- Shares one translation unit (TU) between the instruction-fetch TLB request port and the data TLB request port.
- Sits in cpu7 where the per-port itlb/dtlb stub registers are today. Drives the TU with a single request/done handshake and returns per-port finish pulses and results to the cache interface.
- Data requests have priority. A starvation counter bounds how long instruction requests can wait.

---
 rtl/cpu7_tlb_sched_pkg.sv | 17 +
 rtl/cpu7_tlb_sched_slot.sv | 57 +++++
 rtl/cpu7_tlb_sched.sv | 182 ++++++++++++++++++
 tb/tb_cpu7_tlb_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_tlb_sched_pkg.sv
// Shared types for the cpu7 TLB request scheduler: FSM states and the
// translation result bundle layout {paddr, hit, uncache, exccode}.
package cpu7_tlb_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } state_e;

  localparam int unsigned EXC_W = 6;

  function automatic int unsigned res_w(input int unsigned pa_w);
    return pa_w + 2 + EXC_W;
  endfunction

endpackage

// File: rtl/cpu7_tlb_sched_slot.sv
// Per-port pending request register: capture, clear on cancel/grant,
// overwrite on a repeat request, and bypass of the live request pulse.
module cpu7_tlb_sched_slot
  import cpu7_tlb_sched_pkg::*;
#(
  parameter int unsigned VA_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req,
  input  logic [VA_W-1:0] vaddr,
  input  logic            wr,
  input  logic            cancel,
  input  logic            grant,
  input  logic            busy,
  output logic            cand,
  output logic [VA_W-1:0] iss_vaddr,
  output logic            iss_wr,
  output logic            ovf
);

  logic            valid_q, valid_d;
  logic [VA_W-1:0] vaddr_q, vaddr_d;
  logic            wr_q, wr_d;

  assign cand      = ~cancel & (valid_q | req);
  // A live pulse is always the newest request, so it takes precedence over the slot.
  assign iss_vaddr = req ? vaddr : vaddr_q;
  assign iss_wr    = req ? wr : wr_q;
  assign ovf       = req & ~cancel & (valid_q | busy);

  always_comb begin
    valid_d = valid_q;
    vaddr_d = vaddr_q;
    wr_d    = wr_q;
    if (cancel || grant) begin
      valid_d = 1'b0;
    end else if (req) begin
      valid_d = 1'b1;
      vaddr_d = vaddr;
      wr_d    = wr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      vaddr_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      vaddr_q <= vaddr_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: rtl/cpu7_tlb_sched.sv
// Shares one translation unit between the inst and data TLB ports. Data has
// priority; a starvation counter forces an inst grant after STARVE_MAX data grants.
module cpu7_tlb_sched
  import cpu7_tlb_sched_pkg::*;
#(
  parameter int unsigned VA_W       = 32,
  parameter int unsigned PA_W       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_tlb_req,
  input  logic [VA_W-1:0]  inst_tlb_vaddr,
  input  logic             inst_tlb_cancel,
  input  logic             data_tlb_req,
  input  logic [VA_W-1:0]  data_tlb_vaddr,
  input  logic             data_tlb_wr,
  input  logic             data_tlb_cancel,
  output logic             tu_req,
  output logic [VA_W-1:0]  tu_vaddr,
  output logic             tu_wr,
  output logic             tu_is_inst,
  input  logic             tu_done,
  input  logic [PA_W-1:0]  tu_paddr,
  input  logic             tu_hit,
  input  logic             tu_uncache,
  input  logic [EXC_W-1:0] tu_exccode,
  output logic             itlb_finish,
  output logic [PA_W-1:0]  itlb_paddr,
  output logic             itlb_hit,
  output logic             itlb_uncache,
  output logic [EXC_W-1:0] itlb_exccode,
  output logic             dtlb_finish,
  output logic [PA_W-1:0]  dtlb_paddr,
  output logic             dtlb_hit,
  output logic             dtlb_uncache,
  output logic [EXC_W-1:0] dtlb_exccode,
  output logic             sched_ovf
);

  localparam int unsigned RES_W      = res_w(PA_W);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  state_e           state_q, state_d;
  logic             idle, busy_i, busy_d;
  logic             i_cand, d_cand, i_win, d_win, i_ovf, d_ovf;
  logic             i_iss_wr, d_iss_wr;
  logic [VA_W-1:0]  i_iss_vaddr, d_iss_vaddr;
  logic [3:0]       starve_q, starve_d;
  logic             i_drop_q, i_drop_d, d_drop_q, d_drop_d;
  logic             i_fin_q, i_fin_d, d_fin_q, d_fin_d;
  logic [RES_W-1:0] i_res_q, i_res_d, d_res_q, d_res_d, tu_res;
  logic             ovf_q;

  assign idle   = (state_q == StIdle);
  assign busy_i = (state_q == StBusyI);
  assign busy_d = (state_q == StBusyD);
  assign tu_res = {tu_paddr, tu_hit, tu_uncache, tu_exccode};

  // A request coinciding with tu_done for the same port is a fresh request, not an overflow.
  cpu7_tlb_sched_slot #(.VA_W(VA_W)) u_inst_slot (
    .clk      (clk),
    .resetn   (resetn),
    .req      (inst_tlb_req),
    .vaddr    (inst_tlb_vaddr),
    .wr       (1'b0),
    .cancel   (inst_tlb_cancel),
    .grant    (i_win),
    .busy     (busy_i & ~tu_done),
    .cand     (i_cand),
    .iss_vaddr(i_iss_vaddr),
    .iss_wr   (i_iss_wr),
    .ovf      (i_ovf)
  );

  cpu7_tlb_sched_slot #(.VA_W(VA_W)) u_data_slot (
    .clk      (clk),
    .resetn   (resetn),
    .req      (data_tlb_req),
    .vaddr    (data_tlb_vaddr),
    .wr       (data_tlb_wr),
    .cancel   (data_tlb_cancel),
    .grant    (d_win),
    .busy     (busy_d & ~tu_done),
    .cand     (d_cand),
    .iss_vaddr(d_iss_vaddr),
    .iss_wr   (d_iss_wr),
    .ovf      (d_ovf)
  );

  assign d_win = idle & d_cand & ~(i_cand & (starve_q == STARVE_LIM));
  assign i_win = idle & i_cand & ~d_win;

  assign tu_req     = d_win | i_win;
  assign tu_vaddr   = d_win ? d_iss_vaddr : (i_win ? i_iss_vaddr : '0);
  assign tu_wr      = d_win ? d_iss_wr : (i_win & i_iss_wr);
  assign tu_is_inst = i_win;

  always_comb begin
    starve_d = starve_q;
    if (i_win || !i_cand) begin
      starve_d = '0;
    end else if (d_win && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_fin_d  = 1'b0;
    d_fin_d  = 1'b0;
    i_res_d  = i_res_q;
    d_res_d  = d_res_q;
    i_drop_d = i_drop_q;
    d_drop_d = d_drop_q;
    unique case (state_q)
      StIdle: begin
        if (d_win) begin
          state_d = StBusyD;
        end else if (i_win) begin
          state_d = StBusyI;
        end
      end
      StBusyI: begin
        if (tu_done) begin
          state_d  = StIdle;
          i_drop_d = 1'b0;
          if (!(i_drop_q || inst_tlb_cancel)) begin
            i_fin_d = 1'b1;
            i_res_d = tu_res;
          end
        end else if (inst_tlb_cancel) begin
          i_drop_d = 1'b1;
        end
      end
      StBusyD: begin
        if (tu_done) begin
          state_d  = StIdle;
          d_drop_d = 1'b0;
          if (!(d_drop_q || data_tlb_cancel)) begin
            d_fin_d = 1'b1;
            d_res_d = tu_res;
          end
        end else if (data_tlb_cancel) begin
          d_drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      starve_q <= '0;
      i_drop_q <= 1'b0;
      d_drop_q <= 1'b0;
      i_fin_q  <= 1'b0;
      d_fin_q  <= 1'b0;
      i_res_q  <= '0;
      d_res_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      i_drop_q <= i_drop_d;
      d_drop_q <= d_drop_d;
      i_fin_q  <= i_fin_d;
      d_fin_q  <= d_fin_d;
      i_res_q  <= i_res_d;
      d_res_q  <= d_res_d;
      ovf_q    <= ovf_q | i_ovf | d_ovf;
    end
  end

  assign itlb_finish = i_fin_q;
  assign dtlb_finish = d_fin_q;
  assign {itlb_paddr, itlb_hit, itlb_uncache, itlb_exccode} = i_res_q;
  assign {dtlb_paddr, dtlb_hit, dtlb_uncache, dtlb_exccode} = d_res_q;
  assign sched_ovf = ovf_q;

endmodule

// File: tb/tb_cpu7_tlb_sched.sv
// Bench for cpu7_tlb_sched: directed scenarios followed by random traffic, all
// checked each cycle against a port-indexed behavioural model with a built-in TU.
module tb_cpu7_tlb_sched;

  localparam int unsigned VA_W       = 32;
  localparam int unsigned PA_W       = 32;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_tlb_req, inst_tlb_cancel, data_tlb_req, data_tlb_wr, data_tlb_cancel;
  logic [31:0] inst_tlb_vaddr, data_tlb_vaddr;
  logic        tu_req, tu_wr, tu_is_inst, tu_done, tu_hit, tu_uncache;
  logic [31:0] tu_vaddr, tu_paddr;
  logic [5:0]  tu_exccode;
  logic        itlb_finish, itlb_hit, itlb_uncache, dtlb_finish, dtlb_hit, dtlb_uncache;
  logic [31:0] itlb_paddr, dtlb_paddr;
  logic [5:0]  itlb_exccode, dtlb_exccode;
  logic        sched_ovf;

  always #5 clk = ~clk;

  cpu7_tlb_sched #(.VA_W(VA_W), .PA_W(PA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_tlb_req   (inst_tlb_req),
    .inst_tlb_vaddr (inst_tlb_vaddr),
    .inst_tlb_cancel(inst_tlb_cancel),
    .data_tlb_req   (data_tlb_req),
    .data_tlb_vaddr (data_tlb_vaddr),
    .data_tlb_wr    (data_tlb_wr),
    .data_tlb_cancel(data_tlb_cancel),
    .tu_req         (tu_req),
    .tu_vaddr       (tu_vaddr),
    .tu_wr          (tu_wr),
    .tu_is_inst     (tu_is_inst),
    .tu_done        (tu_done),
    .tu_paddr       (tu_paddr),
    .tu_hit         (tu_hit),
    .tu_uncache     (tu_uncache),
    .tu_exccode     (tu_exccode),
    .itlb_finish    (itlb_finish),
    .itlb_paddr     (itlb_paddr),
    .itlb_hit       (itlb_hit),
    .itlb_uncache   (itlb_uncache),
    .itlb_exccode   (itlb_exccode),
    .dtlb_finish    (dtlb_finish),
    .dtlb_paddr     (dtlb_paddr),
    .dtlb_hit       (dtlb_hit),
    .dtlb_uncache   (dtlb_uncache),
    .dtlb_exccode   (dtlb_exccode),
    .sched_ovf      (sched_ovf)
  );

  int checks = 0;
  int failures = 0;

  // Model state, indexed by port: 0 = inst, 1 = data. svc = port in service or -1.
  bit          pv[2];
  logic [31:0] pa[2];
  bit          pw;
  int          svc;
  bit          drop[2];
  int          starve;
  bit          fin_e[2];
  logic [39:0] res_e[2];
  bit          ovf_e;
  int          wait_cnt;
  logic [31:0] svc_va;

  // Stimulus for the next cycle; one-shot fields are cleared after each cycle.
  bit          rq[2];
  logic [31:0] va[2];
  bit          dwr;
  bit          cn[2];
  bit          stray;
  int          tu_k;
  logic [31:0] xmask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; pa[p] = '0; drop[p] = 0; fin_e[p] = 0; res_e[p] = '0;
    end
    pw = 0; svc = -1; starve = 0; ovf_e = 0; wait_cnt = 0; svc_va = '0;
  endtask

  task automatic drive_idle();
    inst_tlb_req = 0; inst_tlb_vaddr = '0; inst_tlb_cancel = 0;
    data_tlb_req = 0; data_tlb_vaddr = '0; data_tlb_wr = 0; data_tlb_cancel = 0;
    tu_done = 0; tu_paddr = '0; tu_hit = 0; tu_uncache = 0; tu_exccode = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tu_req"}, tu_req, 0);
    chk({tag, "_tu_vaddr"}, tu_vaddr, 0);
    chk({tag, "_tu_flags"}, {tu_wr, tu_is_inst}, 0);
    chk({tag, "_finish"}, {itlb_finish, dtlb_finish}, 0);
    chk({tag, "_ires"}, {itlb_paddr, itlb_hit, itlb_uncache, itlb_exccode}, 0);
    chk({tag, "_dres"}, {dtlb_paddr, dtlb_hit, dtlb_uncache, dtlb_exccode}, 0);
    chk({tag, "_ovf"}, sched_ovf, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    drive_idle();
    #1;
    model_reset();
    chk_zero("rst");
    @(negedge clk);
    resetn = 1;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic cycle();
    bit          done;
    bit          cand[2];
    int          win;
    logic [31:0] ev;
    bit          ew;
    logic [39:0] r;
    @(negedge clk);
    done = 0;
    if (svc >= 0) begin
      wait_cnt--;
      done = (wait_cnt == 0);
    end
    r = {svc_va ^ xmask, 8'($urandom)};
    tu_done = done | stray;
    {tu_paddr, tu_hit, tu_uncache, tu_exccode} = r;
    inst_tlb_req = rq[0]; inst_tlb_vaddr = va[0]; inst_tlb_cancel = cn[0];
    data_tlb_req = rq[1]; data_tlb_vaddr = va[1]; data_tlb_wr = dwr; data_tlb_cancel = cn[1];
    #1;
    for (int p = 0; p < 2; p++) cand[p] = !cn[p] && (pv[p] || rq[p]);
    win = -1;
    if (svc < 0) begin
      if (cand[1] && !(cand[0] && starve == STARVE_MAX)) win = 1;
      else if (cand[0]) win = 0;
    end
    ev = '0; ew = 0;
    chk("tu_req", tu_req, win >= 0);
    if (win >= 0) begin
      ev = rq[win] ? va[win] : pa[win];
      ew = (win == 1) && (rq[1] ? dwr : pw);
      chk("tu_vaddr", tu_vaddr, ev);
      chk("tu_wr", tu_wr, ew);
      chk("tu_is_inst", tu_is_inst, win == 0);
    end
    chk("itlb_finish", itlb_finish, fin_e[0]);
    chk("dtlb_finish", dtlb_finish, fin_e[1]);
    chk("itlb_result", {itlb_paddr, itlb_hit, itlb_uncache, itlb_exccode}, res_e[0]);
    chk("dtlb_result", {dtlb_paddr, dtlb_hit, dtlb_uncache, dtlb_exccode}, res_e[1]);
    chk("sched_ovf", sched_ovf, ovf_e);

    fin_e[0] = 0; fin_e[1] = 0;
    for (int p = 0; p < 2; p++)
      if (rq[p] && !cn[p] && (pv[p] || (svc == p && !done))) ovf_e = 1;
    if (done) begin
      if (!(drop[svc] || cn[svc])) begin
        fin_e[svc] = 1;
        res_e[svc] = r;
      end
      drop[svc] = 0;
      svc = -1;
    end else if (svc >= 0 && cn[svc]) begin
      drop[svc] = 1;
    end
    if (win == 0 || !cand[0]) starve = 0;
    else if (win == 1 && starve < STARVE_MAX) starve++;
    for (int p = 0; p < 2; p++) begin
      if (cn[p] || win == p) pv[p] = 0;
      else if (rq[p]) begin
        pv[p] = 1;
        pa[p] = va[p];
        if (p == 1) pw = dwr;
      end
    end
    if (win >= 0) begin
      svc = win; svc_va = ev; wait_cnt = tu_k;
    end
    rq[0] = 0; rq[1] = 0; cn[0] = 0; cn[1] = 0; stray = 0;
  endtask

  initial begin
    int          ndata;
    bit          inst_seen;
    bit          anyfin;
    logic [31:0] old_d;

    resetn = 0;
    drive_idle();
    model_reset();
    rq[0] = 0; rq[1] = 0; cn[0] = 0; cn[1] = 0; stray = 0;
    va[0] = '0; va[1] = '0; dwr = 0; tu_k = 1; xmask = '0;
    #12;
    chk_zero("por");
    @(negedge clk);
    resetn = 1;

    // Single inst request, k=1: issue same cycle, finish two cycles later.
    rq[0] = 1; va[0] = 32'h1c000010;
    cycle();
    chk("t1_issue", {tu_req, tu_is_inst}, 2'b11);
    cycle();
    cycle();
    chk("t1_finish", itlb_finish, 1);
    chk("t1_paddr", itlb_paddr, 32'h1c000010);
    chk("t1_dfinish", dtlb_finish, 0);
    cycle();
    chk("t1_held", itlb_paddr, 32'h1c000010);

    // Simultaneous inst and data: data first, inst right after tu_done.
    rq[0] = 1; va[0] = 32'h1c000020; rq[1] = 1; va[1] = 32'h00001000; dwr = 1;
    cycle();
    chk("t2_data_first", {tu_req, tu_wr, tu_is_inst}, 3'b110);
    dwr = 0;
    cycle();
    cycle();
    chk("t2_inst_issue", {tu_req, tu_is_inst}, 2'b11);
    chk("t2_inst_vaddr", tu_vaddr, 32'h1c000020);
    chk("t2_dfinish", {dtlb_finish, itlb_finish}, 2'b10);
    cycle();
    cycle();
    chk("t2_ifinish", itlb_finish, 1);

    // Starvation bound: inst waits through exactly STARVE_MAX data grants.
    rq[0] = 1; va[0] = 32'h1c000030; rq[1] = 1; va[1] = 32'h00002000;
    cycle();
    ndata = (tu_req && !tu_is_inst) ? 1 : 0;
    inst_seen = 0;
    for (int i = 0; i < 12 && !inst_seen; i++) begin
      if (svc < 0) begin
        rq[1] = 1; va[1] = $urandom; dwr = 1'($urandom_range(0, 1));
      end
      cycle();
      if (tu_req && tu_is_inst) inst_seen = 1;
      else if (tu_req) ndata++;
    end
    chk("t3_inst_granted", inst_seen, 1);
    chk("t3_data_grants", ndata, STARVE_MAX);
    repeat (4) cycle();
    rq[0] = 1; va[0] = 32'h1c000040; rq[1] = 1; va[1] = 32'h00003000; dwr = 0;
    cycle();
    chk("t3_starve_cleared", {tu_req, tu_is_inst}, 2'b10);
    repeat (5) cycle();

    // Data cancel while in service: no finish, old result kept, next request fine.
    old_d = res_e[1][39:8];
    tu_k = 3;
    rq[1] = 1; va[1] = 32'h00004000;
    cycle();
    anyfin = 0;
    cn[1] = 1;
    cycle();
    repeat (5) begin
      cycle();
      anyfin |= dtlb_finish;
    end
    chk("t4_no_finish", anyfin, 0);
    chk("t4_old_paddr", dtlb_paddr, old_d);
    tu_k = 1;
    rq[1] = 1; va[1] = 32'h00005000;
    cycle();
    cycle();
    cycle();
    chk("t4_next_finish", dtlb_finish, 1);
    chk("t4_next_paddr", dtlb_paddr, 32'h00005000);

    // Second inst request while inst is in service.
    chk("t5_ovf_pre", sched_ovf, 0);
    tu_k = 3;
    rq[0] = 1; va[0] = 32'h1c000100;
    cycle();
    rq[0] = 1; va[0] = 32'h1c000200;
    cycle();
    cycle();
    chk("t5_ovf_set", sched_ovf, 1);
    cycle();
    cycle();
    chk("t5_reissue", {tu_req, tu_is_inst}, 2'b11);
    chk("t5_latest_vaddr", tu_vaddr, 32'h1c000200);
    chk("t5_first_result", itlb_paddr, 32'h1c000100);
    repeat (6) cycle();
    chk("t5_ovf_sticky", sched_ovf, 1);

    // Reset in BUSY_D, then a stray tu_done: ignored, then normal operation.
    rq[1] = 1; va[1] = 32'h00006000;
    cycle();
    cycle();
    do_reset();
    stray = 1;
    cycle();
    repeat (3) cycle();
    chk("t6_no_finish", {itlb_finish, dtlb_finish}, 0);
    chk("t6_ovf_clear", sched_ovf, 0);
    tu_k = 1;
    rq[0] = 1; va[0] = 32'h1c000400;
    cycle();
    chk("t6_issue", {tu_req, tu_is_inst}, 2'b11);
    cycle();
    cycle();
    chk("t6_finish", {itlb_finish, itlb_paddr}, {1'b1, 32'h1c000400});

    // Random traffic against the model.
    xmask = $urandom;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        rq[p] = ($urandom_range(0, 9) < 3);
        va[p] = $urandom;
        cn[p] = ($urandom_range(0, 19) == 0);
      end
      dwr  = 1'($urandom_range(0, 1));
      tu_k = $urandom_range(1, 3);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
